// File: rtl/joy_serial_scan_if.sv
// Pad-chain bus for joy_serial_scan: serial pad lines plus the decoded button outputs.
// master = the scanner, slave = whoever drives the pad side and consumes the results.
interface joy_serial_scan_if #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12
);
  logic                      enable;
  logic                      joy_data;
  logic                      joy_clk;
  logic                      joy_load;
  logic [PLAYERS*BITS-1:0]   joystick;
  logic [PLAYERS-1:0]        present;
  logic                      frame_done;

  modport master (
    input  enable, joy_data,
    output joy_clk, joy_load, joystick, present, frame_done
  );

  modport slave (
    output enable, joy_data,
    input  joy_clk, joy_load, joystick, present, frame_done
  );
endinterface

// File: rtl/joy_serial_scan.sv
// Serial pad-chain scanner: load strobe, shift PLAYERS*BITS bits, debounce whole frames,
// flag disconnected pads (raw field all zeros) and clear their buttons.
module joy_serial_scan #(
  parameter int PLAYERS  = 2,
  parameter int BITS     = 12,
  parameter int CLKDIV   = 24,
  parameter int DEBOUNCE = 2,
  parameter int INVERT   = 1
) (
  input logic               clk,
  input logic               reset_n,
  joy_serial_scan_if.master bus
);
  localparam int          N    = PLAYERS * BITS;
  localparam int          CW   = $clog2(CLKDIV);
  localparam int          IW   = $clog2(N);
  localparam logic [2:0]  SMAX = 3'(DEBOUNCE - 1);
  localparam logic        INV  = (INVERT != 0);

  typedef enum logic [2:0] {IDLE, LOAD, CLK_LO, CLK_HI, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [2:0]      stable;
  logic [1:0]      sync;
  logic [N-1:0]    shift, prev;
  logic            joy_clk_r, joy_load_r, frame_done_r;
  logic [PLAYERS-1:0] present_r;
  logic [N-1:0]    joystick_r;

  logic            tick, same;
  logic [2:0]      stable_nxt;
  logic [PLAYERS-1:0] present_nxt;
  logic [N-1:0]    masked, kept;

  assign tick       = (cnt == CW'(CLKDIV - 1));
  assign same       = (shift == prev);
  assign stable_nxt = !same ? 3'd0 : (stable >= SMAX) ? SMAX : stable + 3'd1;

  // Per-pad presence is judged on the raw line level, before inversion.
  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    assign present_nxt[p]        = |(shift[p*BITS +: BITS] ^ {BITS{INV}});
    assign masked[p*BITS +: BITS] = present_nxt[p] ? shift[p*BITS +: BITS]      : '0;
    assign kept[p*BITS +: BITS]   = present_nxt[p] ? joystick_r[p*BITS +: BITS] : '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt  <= '0;
      sync <= '0;
    end else begin
      cnt  <= tick ? '0 : cnt + 1'b1;
      sync <= {sync[0], bus.joy_data};
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      stable       <= '0;
      shift        <= '0;
      prev         <= '1;
      joy_clk_r    <= 1'b0;
      joy_load_r   <= 1'b0;
      frame_done_r <= 1'b0;
      present_r    <= '0;
      joystick_r   <= '0;
    end else begin
      case (state)
        IDLE: if (tick && bus.enable) begin
          state      <= LOAD;
          joy_load_r <= 1'b1;
          idx        <= '0;
        end
        LOAD: if (tick) begin
          state      <= CLK_LO;
          joy_load_r <= 1'b0;
          idx        <= '0;
        end
        CLK_LO: if (tick) begin
          shift[idx] <= sync[1] ^ INV;
          state      <= CLK_HI;
          joy_clk_r  <= 1'b1;
        end
        CLK_HI: if (tick) begin
          joy_clk_r <= 1'b0;
          if (idx == IW'(N - 1)) begin
            // Frame results are registered here so they are visible alongside frame_done.
            state        <= DONE;
            frame_done_r <= 1'b1;
            present_r    <= present_nxt;
            stable       <= stable_nxt;
            prev         <= shift;
            joystick_r   <= (stable_nxt >= SMAX) ? masked : kept;
          end else begin
            idx   <= idx + 1'b1;
            state <= CLK_LO;
          end
        end
        DONE: begin
          frame_done_r <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  assign bus.joy_clk    = joy_clk_r;
  assign bus.joy_load   = joy_load_r;
  assign bus.frame_done = frame_done_r;
  assign bus.present    = present_r;
  assign bus.joystick   = joystick_r;
endmodule

// File: tb/tb_joy_serial_scan.sv
// Directed bench for joy_serial_scan: pad-chain model, frame timing, debounce, presence, reset.
module tb_joy_serial_scan;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  joy_serial_scan_if #(.PLAYERS(2), .BITS(12)) bus ();

  joy_serial_scan #(.PLAYERS(2), .BITS(12), .CLKDIV(4), .DEBOUNCE(2), .INVERT(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master)
  );

  // Pad chain: bit 0 valid after load, advances on each joy_clk rise; idles high.
  logic [23:0] pad_raw;
  int pad_pos = 0;
  always @(posedge bus.joy_clk or posedge bus.joy_load)
    if (bus.joy_load) pad_pos <= 0;
    else              pad_pos <= pad_pos + 1;
  assign bus.joy_data = (pad_pos < 24) ? pad_raw[pad_pos] : 1'b1;

  // Waveform monitor sampled on the falling edge.
  int cyc = 0, t_load = 0, frame_len = 0, pulses = 0, pulses_done = 0;
  int load_run = 0, load_w = 0, hi_run = 0, hi_min = 999, hi_max = 0;
  int load_rises = 0, done_cnt = 0;
  logic lp = 1'b0, cp = 1'b0, overlap = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    lp  <= bus.joy_load;
    cp  <= bus.joy_clk;
    if (bus.joy_load && !lp) begin
      t_load <= cyc; load_rises <= load_rises + 1; pulses <= 0;
    end else if (bus.joy_clk && !cp) pulses <= pulses + 1;
    if (bus.joy_load) load_run <= load_run + 1;
    else if (lp) begin load_w <= load_run; load_run <= 0; end
    if (bus.joy_clk) hi_run <= hi_run + 1;
    else if (cp) begin
      if (hi_run < hi_min) hi_min <= hi_run;
      if (hi_run > hi_max) hi_max <= hi_run;
      hi_run <= 0;
    end
    if (bus.joy_load && bus.joy_clk) overlap <= 1'b1;
    if (bus.frame_done) begin
      done_cnt <= done_cnt + 1; frame_len <= cyc - t_load; pulses_done <= pulses;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    logic got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      got = bus.frame_done;
    end
    chk({tag, "_done"}, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_pos(input int pos);
    logic got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      got = (pad_pos == pos);
    end
    chk("bit_pos_reached", {31'd0, got}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clk"},  {31'd0, bus.joy_clk},    32'd0);
    chk({tag, "_load"}, {31'd0, bus.joy_load},   32'd0);
    chk({tag, "_joy"},  {8'd0,  bus.joystick},   32'd0);
    chk({tag, "_pres"}, {30'd0, bus.present},    32'd0);
    chk({tag, "_done"}, {31'd0, bus.frame_done}, 32'd0);
  endtask

  int snap;

  initial begin
    bus.enable = 1'b0;
    pad_raw    = ~24'h800001;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n    = 1'b1;
    bus.enable = 1'b1;

    // Frame 1: first capture never matches the reset frame.
    wait_done("f1");
    chk("f1_joy",  {8'd0, bus.joystick}, 32'h000000);
    chk("f1_pres", {30'd0, bus.present}, 32'd3);
    #1;
    chk("f1_len",     frame_len,   32'd196);
    chk("f1_pulses",  pulses_done, 32'd24);
    chk("f1_load_w",  load_w,      32'd4);
    chk("f1_hi_min",  hi_min,      32'd4);
    chk("f1_hi_max",  hi_max,      32'd4);
    chk("f1_overlap", {31'd0, overlap}, 32'd0);

    wait_done("f2");
    chk("f2_joy", {8'd0, bus.joystick}, 32'h800001);

    // Alternating frames: never stable, output holds.
    pad_raw = ~24'h800003;
    wait_done("f3");
    chk("f3_joy", {8'd0, bus.joystick}, 32'h800001);
    pad_raw = ~24'h800001;
    wait_done("f4");
    chk("f4_joy", {8'd0, bus.joystick}, 32'h800001);
    pad_raw = ~24'h800003;
    wait_done("f5");
    chk("f5_joy", {8'd0, bus.joystick}, 32'h800001);

    // Player 1 line held low: disconnected at once, player 0 still debounced.
    pad_raw = {12'h000, ~12'h002};
    wait_done("f6");
    chk("f6_pres", {30'd0, bus.present}, 32'd1);
    chk("f6_joy",  {8'd0, bus.joystick}, 32'h000001);
    wait_done("f7");
    chk("f7_pres", {30'd0, bus.present}, 32'd1);
    chk("f7_joy",  {8'd0, bus.joystick}, 32'h000002);

    // Enable dropped mid-frame: frame completes, then no new load.
    pad_raw = ~24'h000004;
    wait_pos(5);
    bus.enable = 1'b0;
    wait_done("f8");
    chk("f8_joy",  {8'd0, bus.joystick}, 32'h000002);
    chk("f8_pres", {30'd0, bus.present}, 32'd3);
    #1;
    snap = load_rises;
    repeat (300) @(negedge clk);
    chk("idle_load", {31'd0, bus.joy_load}, 32'd0);
    chk("idle_rises", load_rises, snap);
    bus.enable = 1'b1;
    wait_done("f9");
    chk("f9_joy", {8'd0, bus.joystick}, 32'h000004);

    // Reset mid-frame: outputs clear immediately, clean frame afterwards.
    wait_pos(10);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    snap = done_cnt;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    wait_done("f11");
    chk("f11_joy",  {8'd0, bus.joystick}, 32'h000000);
    chk("f11_pres", {30'd0, bus.present}, 32'd3);
    #1;
    chk("f11_len",   frame_len,       32'd196);
    chk("f11_dones", done_cnt - snap, 32'd1);
    wait_done("f12");
    chk("f12_joy", {8'd0, bus.joystick}, 32'h000004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
